// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with EX/MEM, MEM/WB forwarding and load-use detect
// Optional macro SHIFT_VAR_EN: variable shifts take their amount from forwarded rs[4:0].
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_rs_data,
  input  logic [XLEN-1:0]  id_rt_data,
  input  logic [RADDR-1:0] id_rs,
  input  logic [RADDR-1:0] id_rt,
  input  logic [RADDR-1:0] id_rd,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [3:0]       id_alu_ctrl,
  input  logic [4:0]       id_shmt,
  input  logic             id_alu_src,
  input  logic             id_shift_var,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             exmem_reg_write,
  input  logic [RADDR-1:0] exmem_rd,
  input  logic [XLEN-1:0]  exmem_result,
  input  logic             memwb_reg_write,
  input  logic [RADDR-1:0] memwb_rd,
  input  logic [XLEN-1:0]  memwb_result,
  output logic [XLEN-1:0]  bus_a,
  output logic [XLEN-1:0]  bus_b,
  output logic [XLEN-1:0]  shift,
  output logic [3:0]       alu_ctrl,
  output logic [4:0]       shmt,
  output logic [XLEN-1:0]  store_data,
  output logic             ex_valid,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic [RADDR-1:0] ex_rd,
  output logic             load_use_stall
);

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             alu_src;
`ifdef SHIFT_VAR_EN
    logic             shift_var;
`endif
    logic [RADDR-1:0] rs;
    logic [RADDR-1:0] rt;
    logic [RADDR-1:0] rd;
    logic [4:0]       shmt;
    logic [3:0]       alu_ctrl;
    logic [XLEN-1:0]  rs_data;
    logic [XLEN-1:0]  rt_data;
    logic [XLEN-1:0]  imm;
  } stage_t;

  stage_t          stage_q, stage_d;
  logic [XLEN-1:0] fwd_rs, fwd_rt;
  logic [4:0]      shmt_eff;

`ifndef SHIFT_VAR_EN
  logic unused_shift_var;
  assign unused_shift_var = id_shift_var;
`endif

  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (!stall) begin
      stage_d.valid     = id_valid;
      stage_d.reg_write = id_valid & id_reg_write;
      stage_d.mem_read  = id_valid & id_mem_read;
      stage_d.mem_write = id_valid & id_mem_write;
      stage_d.alu_src   = id_alu_src;
`ifdef SHIFT_VAR_EN
      stage_d.shift_var = id_shift_var;
`endif
      stage_d.rs        = id_rs;
      stage_d.rt        = id_rt;
      stage_d.rd        = id_rd;
      stage_d.shmt      = id_shmt;
      stage_d.alu_ctrl  = id_alu_ctrl;
      stage_d.rs_data   = id_rs_data;
      stage_d.rt_data   = id_rt_data;
      stage_d.imm       = id_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // Youngest producer wins; register 0 is hardwired and never forwarded.
  always_comb begin
    fwd_rs = stage_q.rs_data;
    if (stage_q.rs != '0) begin
      if (exmem_reg_write && (exmem_rd == stage_q.rs)) begin
        fwd_rs = exmem_result;
      end else if (memwb_reg_write && (memwb_rd == stage_q.rs)) begin
        fwd_rs = memwb_result;
      end
    end
  end

  always_comb begin
    fwd_rt = stage_q.rt_data;
    if (stage_q.rt != '0) begin
      if (exmem_reg_write && (exmem_rd == stage_q.rt)) begin
        fwd_rt = exmem_result;
      end else if (memwb_reg_write && (memwb_rd == stage_q.rt)) begin
        fwd_rt = memwb_result;
      end
    end
  end

  always_comb begin
    shmt_eff = stage_q.shmt;
`ifdef SHIFT_VAR_EN
    if (stage_q.shift_var) begin
      shmt_eff = fwd_rs[4:0];
    end
`endif
  end

  assign bus_a        = fwd_rs;
  assign store_data   = fwd_rt;
  assign bus_b        = stage_q.alu_src ? stage_q.imm : fwd_rt;
  assign shmt         = shmt_eff;
  assign shift        = bus_b >> shmt_eff;
  assign alu_ctrl     = stage_q.alu_ctrl;
  assign ex_valid     = stage_q.valid;
  assign ex_reg_write = stage_q.reg_write;
  assign ex_mem_read  = stage_q.mem_read;
  assign ex_mem_write = stage_q.mem_write;
  assign ex_rd        = stage_q.rd;

  assign load_use_stall = stage_q.valid & stage_q.mem_read & (stage_q.rd != '0) & id_valid &
                          ((stage_q.rd == id_rs) | (stage_q.rd == id_rt));

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage
// Optional macro SHIFT_VAR_EN selects the expected variable-shift behaviour.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd, id_shmt;
  logic [3:0]  id_alu_ctrl;
  logic        id_alu_src, id_shift_var, id_reg_write, id_mem_read, id_mem_write;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] bus_a, bus_b, shift, store_data;
  logic [3:0]  alu_ctrl;
  logic [4:0]  shmt, ex_rd;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
    .id_alu_ctrl(id_alu_ctrl), .id_shmt(id_shmt), .id_alu_src(id_alu_src),
    .id_shift_var(id_shift_var), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .bus_a(bus_a), .bus_b(bus_b), .shift(shift), .alu_ctrl(alu_ctrl), .shmt(shmt),
    .store_data(store_data), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_rd(ex_rd),
    .load_use_stall(load_use_stall)
  );

  typedef struct packed {
    logic [31:0] a, b, sh;
    logic [3:0]  ac;
    logic [4:0]  sm;
    logic [31:0] sd;
    logic        v, rw, mr, mw;
    logic [4:0]  rd;
    logic        lus;
  } exp_t;

  exp_t  sb_q[$];
  string name_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  // Monitor: every expectation queued before a falling edge is checked on it.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t  e;
      exp_t  got;
      string nm;
      e   = sb_q.pop_front();
      nm  = name_q.pop_front();
      got = '{bus_a, bus_b, shift, alu_ctrl, shmt, store_data, ex_valid, ex_reg_write,
              ex_mem_read, ex_mem_write, ex_rd, load_use_stall};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL %s: got a=%h b=%h sh=%h ac=%h sm=%0d sd=%h v=%b rw=%b mr=%b mw=%b rd=%0d lus=%b ; want a=%h b=%h sh=%h ac=%h sm=%0d sd=%h v=%b rw=%b mr=%b mw=%b rd=%0d lus=%b",
                 nm, got.a, got.b, got.sh, got.ac, got.sm, got.sd, got.v, got.rw, got.mr, got.mw, got.rd, got.lus,
                 e.a, e.b, e.sh, e.ac, e.sm, e.sd, e.v, e.rw, e.mr, e.mw, e.rd, e.lus);
      end
    end
  end

  task automatic expect_out(input string nm, input logic [31:0] a, b, sh, input logic [3:0] ac,
                            input logic [4:0] sm, input logic [31:0] sd,
                            input logic v, rw, mr, mw, input logic [4:0] rd, input logic lus);
    sb_q.push_back('{a, b, sh, ac, sm, sd, v, rw, mr, mw, rd, lus});
    name_q.push_back(nm);
    @(negedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; flush = 0; rst = 0;
    id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_shmt = 0; id_alu_ctrl = 0;
    id_alu_src = 0; id_shift_var = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic load_instr(input logic [4:0] rs, rt, rd, input logic [31:0] rsd, rtd, imm,
                            input logic [3:0] ac, input logic [4:0] sm,
                            input logic src, rw, mr, mw);
    clear_inputs();
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
    id_imm = imm; id_alu_ctrl = ac; id_shmt = sm; id_alu_src = src;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    tick();
    id_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    // Reset with random inputs everywhere.
    rst = 1; stall = 1'($urandom); flush = 1'($urandom); id_valid = 1'($urandom);
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
    id_shmt = 5'($urandom); id_alu_ctrl = 4'($urandom); id_alu_src = 1'($urandom);
    id_shift_var = 1'($urandom); id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
    id_mem_write = 1'($urandom); exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom);
    exmem_result = $urandom; memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom);
    memwb_result = $urandom;
    tick();
    rst = 0;
    expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Forwarding priority, then held under stall while forward sources change.
    load_instr(3, 4, 7, 32'h11, 32'h22, 32'h1234, 4'b0010, 0, 0, 1, 0, 0);
    exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'hAA;
    memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'hBB;
    stall = 1;
    expect_out("fwd_exmem_prio", 32'hAA, 32'h22, 32'h22, 4'b0010, 0, 32'h22, 1, 1, 0, 0, 7, 0);
    exmem_rd = 0;
    expect_out("fwd_memwb_rd0", 32'hBB, 32'h22, 32'h22, 4'b0010, 0, 32'h22, 1, 1, 0, 0, 7, 0);
    exmem_rd = 4; exmem_result = 32'hCC; memwb_rd = 4; memwb_result = 32'hDD;
    expect_out("fwd_rt_exmem", 32'h11, 32'hCC, 32'hCC, 4'b0010, 0, 32'hCC, 1, 1, 0, 0, 7, 0);
    exmem_reg_write = 0;
    expect_out("fwd_rt_memwb", 32'h11, 32'hDD, 32'hDD, 4'b0010, 0, 32'hDD, 1, 1, 0, 0, 7, 0);

    // Immediate operand, rs index 0 never forwarded, store_data stays register path.
    load_instr(0, 4, 8, 32'h55, 32'h22, 32'hFFFF8000, 4'b0001, 8, 1, 1, 0, 0);
    exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'h99;
    memwb_reg_write = 1; memwb_rd = 4; memwb_result = 32'hDD;
    expect_out("imm_idx0", 32'h55, 32'hFFFF8000, 32'h00FFFF80, 4'b0001, 8, 32'hDD, 1, 1, 0, 0, 8, 0);

    // SRA operand: logical shift word, ALU adds the sign fill.
    load_instr(2, 6, 9, 32'h0, 32'h80000010, 32'h0, 4'b1011, 4, 0, 1, 0, 0);
    expect_out("sra_shift", 32'h0, 32'h80000010, 32'h08000001, 4'b1011, 4, 32'h80000010, 1, 1, 0, 0, 9, 0);

    // Load-use detection against live ID indices.
    load_instr(1, 2, 5, 32'h10, 32'h20, 32'h4, 4'b0010, 0, 1, 1, 1, 0);
    stall = 1; id_valid = 1; id_rs = 9; id_rt = 5;
    expect_out("lu_rt_hit", 32'h10, 32'h4, 32'h4, 4'b0010, 0, 32'h20, 1, 1, 1, 0, 5, 1);
    id_valid = 0;
    expect_out("lu_id_invalid", 32'h10, 32'h4, 32'h4, 4'b0010, 0, 32'h20, 1, 1, 1, 0, 5, 0);
    id_valid = 1; id_rs = 5; id_rt = 9;
    expect_out("lu_rs_hit", 32'h10, 32'h4, 32'h4, 4'b0010, 0, 32'h20, 1, 1, 1, 0, 5, 1);
    load_instr(1, 2, 0, 32'h10, 32'h20, 32'h4, 4'b0010, 0, 1, 1, 1, 0);
    id_valid = 1; id_rt = 0;
    expect_out("lu_rd0", 32'h10, 32'h4, 32'h4, 4'b0010, 0, 32'h20, 1, 1, 1, 0, 0, 0);
    load_instr(1, 2, 5, 32'h10, 32'h20, 32'h4, 4'b0010, 0, 1, 1, 0, 0);
    id_valid = 1; id_rt = 5;
    expect_out("lu_no_memread", 32'h10, 32'h4, 32'h4, 4'b0010, 0, 32'h20, 1, 1, 0, 0, 5, 0);

    // id_valid=0 loads a bubble with control bits forced low.
    clear_inputs();
    id_reg_write = 1; id_mem_read = 1; id_mem_write = 1; id_rd = 6;
    tick();
    expect_out("bubble_load", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0);

    // Stall holds instruction A for three cycles while ID changes.
    load_instr(3, 4, 9, 32'h123, 32'h456, 32'h0, 4'b0110, 2, 0, 1, 0, 1);
    expect_out("hold_a_load", 32'h123, 32'h456, 32'h115, 4'b0110, 2, 32'h456, 1, 1, 0, 1, 9, 0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      id_valid = 1; id_rs = 5'(10 + i); id_rt = 5'(20 + i); id_rd = 5'(i + 1);
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_alu_ctrl = 4'(i); id_shmt = 5'(i + 7); id_alu_src = 1;
      id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
      tick();
      expect_out($sformatf("hold_a_%0d", i), 32'h123, 32'h456, 32'h115, 4'b0110, 2, 32'h456,
                 1, 1, 0, 1, 9, 0);
    end
    flush = 1;
    tick();
    flush = 0; id_valid = 0;
    expect_out("flush_and_stall", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset while stalled still clears the stage.
    load_instr(3, 4, 9, 32'h123, 32'h456, 32'h0, 4'b0110, 2, 0, 1, 0, 1);
    stall = 1; rst = 1;
    tick();
    rst = 0;
    expect_out("reset_mid_stall", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Variable shift: amount from forwarded rs when enabled, shamt field otherwise.
    clear_inputs();
    id_valid = 1; id_rs = 7; id_rt = 8; id_rd = 10; id_rt_data = 32'hF0000000;
    id_shmt = 9; id_alu_ctrl = 4'b1010; id_shift_var = 1; id_reg_write = 1;
    tick();
    id_valid = 0;
    exmem_reg_write = 1; exmem_rd = 7; exmem_result = 32'h00000023;
`ifdef SHIFT_VAR_EN
    expect_out("shift_var", 32'h23, 32'hF0000000, 32'h1E000000, 4'b1010, 3, 32'hF0000000, 1, 1, 0, 0, 10, 0);
`else
    expect_out("shift_var_off", 32'h23, 32'hF0000000, 32'h00780000, 4'b1010, 9, 32'hF0000000, 1, 1, 0, 0, 10, 0);
`endif

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
